// File: rtl/bus_dev_endpoint.sv
// Device-side bus endpoint: TX show-ahead FIFO toward the arbiter,
// RX FIFO with destination-ID filter toward the local consumer.
module bus_dev_endpoint #(
    parameter int           pckg_sz   = 16,
    parameter int           depth     = 8,
    parameter logic [7:0]   id        = 8'h00,
    parameter logic [7:0]   broadcast = 8'h8F
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_empty,
    output logic [7:0]         rx_drop_cnt,
    output logic [7:0]         rx_miss_cnt
);

    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef logic [pckg_sz-1:0] pkt_t;

    pkt_t          tx_mem_q [depth];
    pkt_t          tx_mem_d [depth];
    logic [AW-1:0] tx_wptr_q, tx_wptr_d;
    logic [AW-1:0] tx_rptr_q, tx_rptr_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;

    pkt_t          rx_mem_q [depth];
    pkt_t          rx_mem_d [depth];
    logic [AW-1:0] rx_wptr_q, rx_wptr_d;
    logic [AW-1:0] rx_rptr_q, rx_rptr_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    pkt_t          rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    drop_q, drop_d;
    logic [7:0]    miss_q, miss_d;

    logic       tx_do_pop, tx_do_wr;
    logic       rx_hit, rx_do_rd, rx_do_wr;
    logic [7:0] dest;

    assign dest = D_push[pckg_sz-1 -: 8];

    // Output decode; D_pop is gated so an empty FIFO presents zero.
    always_comb begin
        pndng       = (tx_cnt_q != '0);
        D_pop       = pndng ? tx_mem_q[tx_rptr_q] : '0;
        tx_full     = (tx_cnt_q == FULL_CNT);
        rx_empty    = (rx_cnt_q == '0);
        rx_data     = rx_data_q;
        rx_valid    = rx_valid_q;
        rx_drop_cnt = drop_q;
        rx_miss_cnt = miss_q;
    end

    // TX FIFO next state; a pop on a full FIFO frees room for a same-cycle write.
    always_comb begin
        tx_mem_d  = tx_mem_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        tx_do_pop = pop && (tx_cnt_q != '0);
        tx_do_wr  = tx_wr && ((tx_cnt_q != FULL_CNT) || tx_do_pop);
        if (tx_do_wr) begin
            tx_mem_d[tx_wptr_q] = tx_data;
            tx_wptr_d = tx_wptr_q + PTR_ONE;
        end
        if (tx_do_pop) begin
            tx_rptr_d = tx_rptr_q + PTR_ONE;
        end
        unique case ({tx_do_wr, tx_do_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
            2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    // RX filter, FIFO next state and saturating miss/drop counters.
    always_comb begin
        rx_mem_d   = rx_mem_q;
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_cnt_d   = rx_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        drop_d     = drop_q;
        miss_d     = miss_q;
        rx_hit     = push && ((dest == id) || (dest == broadcast));
        rx_do_rd   = rx_rd && (rx_cnt_q != '0);
        rx_do_wr   = rx_hit && ((rx_cnt_q != FULL_CNT) || rx_do_rd);
        if (push && !rx_hit && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 8'd1;
        end
        if (rx_hit && !rx_do_wr && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        if (rx_do_wr) begin
            rx_mem_d[rx_wptr_q] = D_push;
            rx_wptr_d = rx_wptr_q + PTR_ONE;
        end
        if (rx_do_rd) begin
            rx_data_d  = rx_mem_q[rx_rptr_q];
            rx_valid_d = 1'b1;
            rx_rptr_d  = rx_rptr_q + PTR_ONE;
        end
        unique case ({rx_do_wr, rx_do_rd})
            2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
            2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // State registers; reset discards all buffered packets.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_cnt_q   <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            drop_q     <= '0;
            miss_q     <= '0;
        end else begin
            tx_mem_q   <= tx_mem_d;
            rx_mem_q   <= rx_mem_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            drop_q     <= drop_d;
            miss_q     <= miss_d;
        end
    end

endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Directed bench for bus_dev_endpoint: vector table plus hand sequences,
// and a five-endpoint routed-bus scenario.
module tb_bus_dev_endpoint;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop = 1'b0;
    logic        push = 1'b0;
    logic [15:0] D_push = '0;
    logic        tx_wr = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_full;
    logic        rx_rd = 1'b0;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_empty;
    logic [7:0]  rx_drop_cnt;
    logic [7:0]  rx_miss_cnt;

    logic [4:0]  b_pndng;
    logic [15:0] b_dpop [5];
    logic [4:0]  b_pop = '0;
    logic [4:0]  b_push = '0;
    logic [15:0] b_dpush = '0;
    logic [4:0]  b_tx_wr = '0;
    logic [15:0] b_tx_data = '0;
    logic [4:0]  b_tx_full;
    logic [4:0]  b_rx_rd = '0;
    logic [15:0] b_rxd [5];
    logic [4:0]  b_rxv;
    logic [4:0]  b_rxe;
    logic [7:0]  b_drop [5];
    logic [7:0]  b_miss [5];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bus_dev_endpoint #(
        .pckg_sz(16), .depth(8), .id(8'h02), .broadcast(8'h8F)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push), .tx_wr(tx_wr),
        .tx_data(tx_data), .tx_full(tx_full), .rx_rd(rx_rd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_empty(rx_empty),
        .rx_drop_cnt(rx_drop_cnt), .rx_miss_cnt(rx_miss_cnt)
    );

    for (genvar k = 0; k < 5; k++) begin : g_ep
        bus_dev_endpoint #(
            .pckg_sz(16), .depth(8), .id(8'(k)), .broadcast(8'h8F)
        ) u_ep (
            .clk(clk), .reset(reset), .pndng(b_pndng[k]),
            .D_pop(b_dpop[k]), .pop(b_pop[k]), .push(b_push[k]),
            .D_push(b_dpush), .tx_wr(b_tx_wr[k]), .tx_data(b_tx_data),
            .tx_full(b_tx_full[k]), .rx_rd(b_rx_rd[k]),
            .rx_data(b_rxd[k]), .rx_valid(b_rxv[k]), .rx_empty(b_rxe[k]),
            .rx_drop_cnt(b_drop[k]), .rx_miss_cnt(b_miss[k])
        );
    end

    typedef struct packed {
        logic        tx_wr;
        logic [15:0] tx_data;
        logic        pop;
        logic        push;
        logic [15:0] d_push;
        logic        rx_rd;
        logic        e_pndng;
        logic [15:0] e_dpop;
        logic        e_full;
        logic        e_rxe;
        logic        e_rxv;
        logic [15:0] e_rxd;
        logic [7:0]  e_miss;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tx_wr = 1'b0;
        pop = 1'b0;
        push = 1'b0;
        rx_rd = 1'b0;
        b_pop = '0;
        b_push = '0;
        b_tx_wr = '0;
        b_rx_rd = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        logic [15:0] exp_d;
        logic [15:0] pkt;
        int sent;
        int budget;

        vecs[0]  = '{1'b0, 16'h0, 1'b0, 1'b1, 16'h02AA, 1'b0,
                     1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 8'd0, 8'd0};
        vecs[1]  = '{1'b0, 16'h0, 1'b0, 1'b1, 16'h8F55, 1'b0,
                     1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 8'd0, 8'd0};
        vecs[2]  = '{1'b0, 16'h0, 1'b0, 1'b1, 16'h0333, 1'b0,
                     1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 8'd1, 8'd0};
        vecs[3]  = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1,
                     1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h02AA, 8'd1, 8'd0};
        vecs[4]  = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1,
                     1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h8F55, 8'd1, 8'd0};
        vecs[5]  = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1,
                     1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h8F55, 8'd1, 8'd0};
        vecs[6]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b0,
                     1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h8F55, 8'd1, 8'd0};
        vecs[7]  = '{1'b1, 16'h5678, 1'b1, 1'b0, 16'h0, 1'b0,
                     1'b1, 16'h5678, 1'b0, 1'b1, 1'b0, 16'h8F55, 8'd1, 8'd0};
        vecs[8]  = '{1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0,
                     1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h8F55, 8'd1, 8'd0};
        vecs[9]  = '{1'b1, 16'h9ABC, 1'b1, 1'b0, 16'h0, 1'b0,
                     1'b1, 16'h9ABC, 1'b0, 1'b1, 1'b0, 16'h8F55, 8'd1, 8'd0};
        vecs[10] = '{1'b0, 16'h0, 1'b1, 1'b1, 16'h0255, 1'b1,
                     1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h8F55, 8'd1, 8'd0};
        vecs[11] = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1,
                     1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0255, 8'd1, 8'd0};
        vecs[12] = '{1'b0, 16'h0, 1'b0, 1'b1, 16'h0102, 1'b0,
                     1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0255, 8'd2, 8'd0};

        idle();
        #2;
        chk("rst_pndng", 32'(pndng), 32'd0);
        chk("rst_rx_empty", 32'(rx_empty), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            tx_wr   = vecs[i].tx_wr;
            tx_data = vecs[i].tx_data;
            pop     = vecs[i].pop;
            push    = vecs[i].push;
            D_push  = vecs[i].d_push;
            rx_rd   = vecs[i].rx_rd;
            step();
            chk($sformatf("v%0d_pndng", i), 32'(pndng), 32'(vecs[i].e_pndng));
            chk($sformatf("v%0d_dpop", i), 32'(D_pop), 32'(vecs[i].e_dpop));
            chk($sformatf("v%0d_full", i), 32'(tx_full), 32'(vecs[i].e_full));
            chk($sformatf("v%0d_rxe", i), 32'(rx_empty), 32'(vecs[i].e_rxe));
            chk($sformatf("v%0d_rxv", i), 32'(rx_valid), 32'(vecs[i].e_rxv));
            chk($sformatf("v%0d_rxd", i), 32'(rx_data), 32'(vecs[i].e_rxd));
            chk($sformatf("v%0d_miss", i), 32'(rx_miss_cnt), 32'(vecs[i].e_miss));
            chk($sformatf("v%0d_drop", i), 32'(rx_drop_cnt), 32'(vecs[i].e_drop));
        end
        idle();

        // TX fill, ignored overflow write, simultaneous write+pop when full
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tx_wr = 1'b1;
            tx_data = 16'h0100 + 16'(i);
            step();
            if (i == 0) chk("tx_first_pndng", 32'(pndng), 32'd1);
        end
        tx_wr = 1'b0;
        chk("tx_full_8", 32'(tx_full), 32'd1);
        tx_wr = 1'b1;
        tx_data = 16'h01FF;
        step();
        tx_wr = 1'b0;
        chk("tx_9th_full", 32'(tx_full), 32'd1);
        chk("tx_9th_head", 32'(D_pop), 32'h0100);
        tx_wr = 1'b1;
        tx_data = 16'h0AAA;
        pop = 1'b1;
        step();
        idle();
        chk("tx_simul_full", 32'(tx_full), 32'd1);
        chk("tx_simul_head", 32'(D_pop), 32'h0101);
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 7) ? 16'h0101 + 16'(i) : 16'h0AAA;
            chk($sformatf("tx_drain%0d", i), 32'(D_pop), 32'(exp_d));
            pop = 1'b1;
            step();
            pop = 1'b0;
        end
        chk("tx_drained_pndng", 32'(pndng), 32'd0);
        chk("tx_drained_full", 32'(tx_full), 32'd0);
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("tx_pop_empty", 32'(pndng), 32'd0);

        // RX overflow, simultaneous push+read when full, drop saturation
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push = 1'b1;
            D_push = 16'h0200 + 16'(i);
            step();
        end
        push = 1'b0;
        chk("rx_ovf_drop", 32'(rx_drop_cnt), 32'd2);
        chk("rx_ovf_miss", 32'(rx_miss_cnt), 32'd0);
        push = 1'b1;
        D_push = 16'h02EE;
        rx_rd = 1'b1;
        step();
        idle();
        chk("rx_simul_drop", 32'(rx_drop_cnt), 32'd2);
        chk("rx_simul_valid", 32'(rx_valid), 32'd1);
        chk("rx_simul_data", 32'(rx_data), 32'h0200);
        push = 1'b1;
        D_push = 16'h8F00;
        for (int i = 0; i < 300; i++) step();
        push = 1'b0;
        chk("rx_drop_sat", 32'(rx_drop_cnt), 32'd255);
        for (int i = 0; i < 8; i++) begin
            rx_rd = 1'b1;
            step();
            exp_d = (i < 7) ? 16'h0201 + 16'(i) : 16'h02EE;
            chk($sformatf("rx_rd%0d_valid", i), 32'(rx_valid), 32'd1);
            chk($sformatf("rx_rd%0d_data", i), 32'(rx_data), 32'(exp_d));
        end
        rx_rd = 1'b0;
        chk("rx_after_empty", 32'(rx_empty), 32'd1);
        step();
        chk("rx_hold_valid", 32'(rx_valid), 32'd0);
        chk("rx_hold_data", 32'(rx_data), 32'h02EE);

        // Asynchronous reset in the middle of traffic
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tx_wr = 1'b1;
            tx_data = 16'h0300 + 16'(i);
            step();
        end
        tx_wr = 1'b0;
        push = 1'b1;
        D_push = 16'h02AA;
        step();
        D_push = 16'h0303;
        step();
        push = 1'b0;
        chk("pre_rst_pndng", 32'(pndng), 32'd1);
        chk("pre_rst_miss", 32'(rx_miss_cnt), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_pndng", 32'(pndng), 32'd0);
        chk("arst_dpop", 32'(D_pop), 32'd0);
        chk("arst_full", 32'(tx_full), 32'd0);
        chk("arst_rx_empty", 32'(rx_empty), 32'd1);
        chk("arst_miss", 32'(rx_miss_cnt), 32'd0);
        chk("arst_drop", 32'(rx_drop_cnt), 32'd0);
        step();
        reset = 1'b1;
        step();

        // Five endpoints on a routed bus; device 0 sends two packets
        do_reset();
        b_tx_wr[0] = 1'b1;
        b_tx_data = 16'h03C3;
        step();
        b_tx_data = 16'h8F11;
        step();
        b_tx_wr = '0;
        sent = 0;
        budget = 20;
        while (sent < 2 && budget > 0) begin
            b_pop = '0;
            b_push = '0;
            if (b_pndng[0]) begin
                pkt = b_dpop[0];
                b_dpush = pkt;
                b_pop[0] = 1'b1;
                if (pkt[15:8] == 8'h8F) b_push = 5'b11110;
                else if (pkt[15:8] < 8'd5) b_push[pkt[10:8]] = 1'b1;
                sent++;
            end
            step();
            budget--;
        end
        b_pop = '0;
        b_push = '0;
        chk("bus_sent", 32'(sent), 32'd2);
        for (int k = 1; k < 5; k++) begin
            if (k == 3) begin
                b_rx_rd[k] = 1'b1;
                step();
                b_rx_rd[k] = 1'b0;
                chk("bus_ep3_v0", 32'(b_rxv[k]), 32'd1);
                chk("bus_ep3_d0", 32'(b_rxd[k]), 32'h03C3);
            end
            b_rx_rd[k] = 1'b1;
            step();
            b_rx_rd[k] = 1'b0;
            chk($sformatf("bus_ep%0d_v", k), 32'(b_rxv[k]), 32'd1);
            chk($sformatf("bus_ep%0d_d", k), 32'(b_rxd[k]), 32'h8F11);
            chk($sformatf("bus_ep%0d_empty", k), 32'(b_rxe[k]), 32'd1);
            chk($sformatf("bus_ep%0d_miss", k), 32'(b_miss[k]), 32'd0);
            chk($sformatf("bus_ep%0d_drop", k), 32'(b_drop[k]), 32'd0);
        end
        chk("bus_ep0_pndng", 32'(b_pndng[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
